// File: rtl/aibnd_clkpol_det.sv
// AIB clock-polarity detector: aligns to a repeating training word (or its inverse), confirms it MATCH_CNT times, reports inv_sel.
// Registered outputs; decisions use registered sr and take effect on the next edge. No flow control; start is level-sampled.
module aibnd_clkpol_det #(
  parameter logic [7:0] TRAIN_WORD = 8'hF1,
  parameter int         MATCH_CNT  = 4,
  parameter int         TIMEOUT    = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic data_in,
  input  logic vccl_aibnd,
  input  logic vssl_aibnd,
  output logic inv_sel,
  output logic lock,
  output logic fail,
  output logic busy
);

  localparam logic [7:0]  INV_WORD  = ~TRAIN_WORD;
  localparam logic [3:0]  MATCH_LIM = 4'(MATCH_CNT);
  localparam logic [15:0] TO_LIM    = 16'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, SEARCH, VERIFY, LOCKED, FAIL} state_t;

  state_t      state, state_n;
  logic [7:0]  sr, sr_n;
  logic [3:0]  scnt, scnt_n;
  logic [15:0] tcnt, tcnt_n;
  logic [3:0]  mcnt, mcnt_n;
  logic [2:0]  phase, phase_n;
  logic        pol, pol_n;
  logic        inv_n;
  logic        timeout;
  logic [7:0]  exp_word;

  logic unused_pwr;
  assign unused_pwr = vccl_aibnd ^ vssl_aibnd;

  assign timeout  = (tcnt == TO_LIM);
  assign exp_word = pol ? INV_WORD : TRAIN_WORD;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sr      <= '0;
      scnt    <= '0;
      tcnt    <= '0;
      mcnt    <= '0;
      phase   <= '0;
      pol     <= 1'b0;
      inv_sel <= 1'b0;
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      scnt    <= scnt_n;
      tcnt    <= tcnt_n;
      mcnt    <= mcnt_n;
      phase   <= phase_n;
      pol     <= pol_n;
      inv_sel <= inv_n;
    end
  end

  always_comb begin
    state_n = state;
    sr_n    = sr;
    scnt_n  = scnt;
    tcnt_n  = tcnt;
    mcnt_n  = mcnt;
    phase_n = phase;
    pol_n   = pol;
    inv_n   = inv_sel;
    case (state)
      IDLE, LOCKED, FAIL: begin
        if (start) begin
          state_n = SEARCH;
          sr_n    = '0;
          scnt_n  = '0;
          tcnt_n  = '0;
          mcnt_n  = '0;
        end
      end
      SEARCH: begin
        sr_n   = {sr[6:0], data_in};
        tcnt_n = tcnt + 16'd1;
        if (scnt != 4'd8) scnt_n = scnt + 4'd1;
        if (scnt == 4'd8 && (sr == TRAIN_WORD || sr == INV_WORD)) begin
          pol_n   = (sr == INV_WORD);
          mcnt_n  = 4'd1;
          phase_n = 3'd0;
          // A single required match is already lock-producing, so it beats timeout.
          if (MATCH_LIM == 4'd1) begin
            state_n = LOCKED;
            inv_n   = pol_n;
          end else if (timeout) begin
            state_n = FAIL;
          end else begin
            state_n = VERIFY;
          end
        end else if (timeout) begin
          state_n = FAIL;
        end
      end
      VERIFY: begin
        sr_n    = {sr[6:0], data_in};
        tcnt_n  = tcnt + 16'd1;
        phase_n = phase + 3'd1;
        if (phase == 3'd7) begin
          if (sr == exp_word) begin
            mcnt_n = mcnt + 4'd1;
            if (mcnt_n == MATCH_LIM) begin
              state_n = LOCKED;
              inv_n   = pol;
            end else if (timeout) begin
              state_n = FAIL;
            end
          end else begin
            // Sample counter stays full so the next SEARCH edge can realign at once.
            mcnt_n  = 4'd0;
            scnt_n  = 4'd8;
            state_n = timeout ? FAIL : SEARCH;
          end
        end else if (timeout) begin
          state_n = FAIL;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == SEARCH) || (state == VERIFY);
  assign lock = (state == LOCKED);
  assign fail = (state == FAIL);

endmodule

// File: tb/tb_aibnd_clkpol_det.sv
// Directed bench for aibnd_clkpol_det: lock on true/inverted word, corrupted word, timeout, reset and start-held cases.
module tb_aibnd_clkpol_det;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic data_in = 1'b0;
  logic vccl_aibnd = 1'b1;
  logic vssl_aibnd = 1'b0;
  logic inv_sel, lock, fail, busy;

  int n_cmp = 0;
  int n_err = 0;

  aibnd_clkpol_det dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data_in    (data_in),
    .vccl_aibnd (vccl_aibnd),
    .vssl_aibnd (vssl_aibnd),
    .inv_sel    (inv_sel),
    .lock       (lock),
    .fail       (fail),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Drive inputs for one edge, then sample 1 time unit after it.
  task automatic tick(input logic s, input logic d);
    start   = s;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  // Bit of a repeating MSB-first word sampled at edge n (stream starts at edge 1).
  function automatic logic wbit(input logic [7:0] w, input int n);
    int idx;
    idx = 7 - ((n - 1) % 8);
    return w[idx];
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (inv_sel !== 1'b0) begin n_err++; $display("FAIL reset_inv_sel: got %b want 0", inv_sel); end
    n_cmp++; if (lock !== 1'b0) begin n_err++; $display("FAIL reset_lock: got %b want 0", lock); end
    n_cmp++; if (fail !== 1'b0) begin n_err++; $display("FAIL reset_fail: got %b want 0", fail); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    tick(1'b0, 1'b1);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_no_start_busy: got %b want 0", busy); end
  endtask

  // Start at edge 0, word stream from edge 1; first match at edge 9, verifies at 17/25/33.
  task automatic test_lock(input logic [7:0] w, input logic exp_inv);
    apply_reset();
    tick(1'b1, 1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL lock_%h_busy_e1: got %b want 1", w, busy); end
    for (int e = 1; e <= 33; e++) begin
      tick(1'b0, wbit(w, e));
      if (e == 32) begin
        n_cmp++; if (lock !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL lock_%h_e32: lock=%b busy=%b want 0/1", w, lock, busy); end
      end
    end
    n_cmp++; if (lock !== 1'b1) begin n_err++; $display("FAIL lock_%h_e33_lock: got %b want 1", w, lock); end
    n_cmp++; if (inv_sel !== exp_inv) begin n_err++; $display("FAIL lock_%h_inv_sel: got %b want %b", w, inv_sel, exp_inv); end
    n_cmp++; if (busy !== 1'b0 || fail !== 1'b0) begin n_err++; $display("FAIL lock_%h_excl: busy=%b fail=%b want 0/0", w, busy, fail); end
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    n_cmp++; if (lock !== 1'b1 || inv_sel !== exp_inv) begin n_err++; $display("FAIL lock_%h_hold: lock=%b inv=%b", w, lock, inv_sel); end
  endtask

  // Word 2 (edges 17..24) sent as F0: mismatch at edge 25, realign at 33, lock after 57.
  task automatic test_corrupt();
    logic [7:0] w;
    apply_reset();
    tick(1'b1, 1'b0);
    for (int e = 1; e <= 57; e++) begin
      w = (e >= 17 && e <= 24) ? 8'hF0 : 8'hF1;
      tick(1'b0, wbit(w, e));
      if (e == 25) begin
        n_cmp++; if (busy !== 1'b1 || lock !== 1'b0) begin n_err++; $display("FAIL corrupt_e25: busy=%b lock=%b want 1/0", busy, lock); end
      end
      if (e == 33) begin
        n_cmp++; if (lock !== 1'b0) begin n_err++; $display("FAIL corrupt_e33_lock: got %b want 0", lock); end
      end
      if (e == 56) begin
        n_cmp++; if (lock !== 1'b0) begin n_err++; $display("FAIL corrupt_e56_lock: got %b want 0", lock); end
      end
    end
    n_cmp++; if (lock !== 1'b1 || inv_sel !== 1'b0) begin n_err++; $display("FAIL corrupt_e57: lock=%b inv=%b want 1/0", lock, inv_sel); end
  endtask

  task automatic test_timeout();
    apply_reset();
    tick(1'b1, 1'b0);
    for (int e = 1; e <= 1024; e++) begin
      tick(1'b0, 1'b0);
      if (e == 1023) begin
        n_cmp++; if (fail !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL timeout_e1023: fail=%b busy=%b want 0/1", fail, busy); end
      end
    end
    n_cmp++; if (fail !== 1'b1) begin n_err++; $display("FAIL timeout_fail: got %b want 1", fail); end
    n_cmp++; if (busy !== 1'b0 || lock !== 1'b0) begin n_err++; $display("FAIL timeout_excl: busy=%b lock=%b want 0/0", busy, lock); end
    tick(1'b1, 1'b0);
    n_cmp++; if (fail !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL timeout_restart: fail=%b busy=%b want 0/1", fail, busy); end
  endtask

  // Reset (with start also high) at edge 20, inside VERIFY.
  task automatic test_reset_mid_verify();
    apply_reset();
    tick(1'b1, 1'b0);
    for (int e = 1; e <= 19; e++) tick(1'b0, wbit(8'hF1, e));
    reset = 1'b1;
    tick(1'b1, wbit(8'hF1, 20));
    reset = 1'b0;
    n_cmp++; if ({inv_sel, lock, fail, busy} !== 4'b0000) begin n_err++; $display("FAIL midreset_outs: got %b want 0000", {inv_sel, lock, fail, busy}); end
    for (int e = 21; e <= 50; e++) tick(1'b0, wbit(8'hF1, e));
    n_cmp++; if ({lock, fail, busy} !== 3'b000) begin n_err++; $display("FAIL midreset_idle: got %b want 000", {lock, fail, busy}); end
  endtask

  task automatic test_start_held();
    apply_reset();
    tick(1'b1, 1'b0);
    for (int e = 1; e <= 33; e++) tick(1'b1, wbit(8'h0E, e));
    n_cmp++; if (lock !== 1'b1 || inv_sel !== 1'b1) begin n_err++; $display("FAIL held_lock: lock=%b inv=%b want 1/1", lock, inv_sel); end
    tick(1'b1, wbit(8'h0E, 34));
    n_cmp++; if (lock !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL held_research: lock=%b busy=%b want 0/1", lock, busy); end
    n_cmp++; if (inv_sel !== 1'b1) begin n_err++; $display("FAIL held_inv_retain: got %b want 1", inv_sel); end
  endtask

  initial begin
    test_reset();
    test_lock(8'hF1, 1'b0);
    test_lock(8'h0E, 1'b1);
    test_corrupt();
    test_timeout();
    test_reset_mid_verify();
    test_start_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
